// File: rtl/retro_memory_arbiter.sv
// retro_memory_arbiter
//   Round-robin arbiter placed directly in front of the HyperRAM controller.
//   It merges NumInitiators SRAM-style requesters into one target port and
//   forwards one transaction at a time. All outputs are registered, and each
//   completion is routed back to the initiator that was granted.
//
//   Optional feature macro: RETRO_ARBITER_LOCK_EN
//     When defined, this adds the InitLock input. If the granted initiator
//     holds its lock bit on the completing beat, it keeps the grant for its
//     next request. This keeps burst beats (for example cache-line fills)
//     contiguous.
//
// Ports
//   Clk, nReset      clock, asynchronous active-low reset
//   InitRequest      per-initiator request, held until the matching InitAck
//   InitWrite        per-initiator direction (1 = write, 0 = read)
//   InitAddress      packed addresses, port i at [i*AW +: AW]
//   InitDataIn       packed write data, port i at [i*DW +: DW]
//   InitLock         per-initiator lock request (RETRO_ARBITER_LOCK_EN only)
//   InitAck          one-cycle completion pulse to the granted initiator
//   InitDataOut      shared read data, valid while an InitAck bit is high
//   TgtRequest       request to the controller, held until TgtAck
//   TgtWrite         write strobe to the controller
//   TgtAddress       address to the controller
//   TgtDataOut       write data to the controller
//   TgtAck           one-cycle completion pulse from the controller
//   TgtDataIn        read data from the controller, valid with TgtAck
module retro_memory_arbiter #(
    parameter int unsigned NumInitiators   = 2,
    parameter int unsigned AddressBusWidth = 16,
    parameter int unsigned DataBusWidth    = 8
) (
    input  logic                                     Clk,
    input  logic                                     nReset,
    input  logic [NumInitiators-1:0]                 InitRequest,
    input  logic [NumInitiators-1:0]                 InitWrite,
    input  logic [NumInitiators*AddressBusWidth-1:0] InitAddress,
    input  logic [NumInitiators*DataBusWidth-1:0]    InitDataIn,
`ifdef RETRO_ARBITER_LOCK_EN
    input  logic [NumInitiators-1:0]                 InitLock,
`endif
    output logic [NumInitiators-1:0]                 InitAck,
    output logic [DataBusWidth-1:0]                  InitDataOut,
    output logic                                     TgtRequest,
    output logic                                     TgtWrite,
    output logic [AddressBusWidth-1:0]               TgtAddress,
    output logic [DataBusWidth-1:0]                  TgtDataOut,
    input  logic                                     TgtAck,
    input  logic [DataBusWidth-1:0]                  TgtDataIn
);

    localparam int unsigned GrantWidth = (NumInitiators > 1) ? $clog2(NumInitiators) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StAck
    } state_e;

    state_e                     state_q,      state_d;
    logic [GrantWidth-1:0]      grant_q,      grant_d;
    logic [GrantWidth-1:0]      last_grant_q, last_grant_d;
    logic [NumInitiators-1:0]   init_ack_q,   init_ack_d;
    logic [DataBusWidth-1:0]    init_data_q,  init_data_d;
    logic                       tgt_req_q,    tgt_req_d;
    logic                       tgt_write_q,  tgt_write_d;
    logic [AddressBusWidth-1:0] tgt_addr_q,   tgt_addr_d;
    logic [DataBusWidth-1:0]    tgt_data_q,   tgt_data_d;
`ifdef RETRO_ARBITER_LOCK_EN
    logic                       locked_q,     locked_d;
`endif

    logic                  scan_found;
    logic [GrantWidth-1:0] scan_idx;
    logic [GrantWidth-1:0] cand;
    logic                  sel_valid;
    logic [GrantWidth-1:0] sel_idx;

    // Round-robin scan: LastGrant+1, LastGrant+2, ... modulo NumInitiators.
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        cand       = '0;
        for (int unsigned off = 1; off <= NumInitiators; off++) begin
            cand = GrantWidth'((32'(last_grant_q) + off) % NumInitiators);
            if (!scan_found && InitRequest[cand]) begin
                scan_found = 1'b1;
                scan_idx   = cand;
            end
        end
    end

    // While locked, only the locked owner can win. If the owner has dropped
    // its request, the normal scan result is used on the same edge.
    always_comb begin
        sel_valid = scan_found;
        sel_idx   = scan_idx;
`ifdef RETRO_ARBITER_LOCK_EN
        if (locked_q && InitRequest[grant_q]) begin
            sel_valid = 1'b1;
            sel_idx   = grant_q;
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        init_ack_d   = init_ack_q;
        init_data_d  = init_data_q;
        tgt_req_d    = tgt_req_q;
        tgt_write_d  = tgt_write_q;
        tgt_addr_d   = tgt_addr_q;
        tgt_data_d   = tgt_data_q;
`ifdef RETRO_ARBITER_LOCK_EN
        locked_d     = locked_q;
`endif

        unique case (state_q)
            StIdle: begin
                init_ack_d = '0;
`ifdef RETRO_ARBITER_LOCK_EN
                if (locked_q && !InitRequest[grant_q]) begin
                    locked_d = 1'b0;
                end
`endif
                if (sel_valid) begin
                    grant_d     = sel_idx;
                    tgt_req_d   = 1'b1;
                    tgt_write_d = InitWrite[sel_idx];
                    tgt_addr_d  = InitAddress[32'(sel_idx)*AddressBusWidth +: AddressBusWidth];
                    tgt_data_d  = InitDataIn[32'(sel_idx)*DataBusWidth +: DataBusWidth];
                    state_d     = StBusy;
                end
            end

            StBusy: begin
                // Initiator inputs are ignored here. The transaction runs to
                // TgtAck even if the granted request is withdrawn early.
                if (TgtAck) begin
                    tgt_req_d           = 1'b0;
                    init_ack_d          = '0;
                    init_ack_d[grant_q] = 1'b1;
                    if (!tgt_write_q) begin
                        init_data_d = TgtDataIn;
                    end
`ifdef RETRO_ARBITER_LOCK_EN
                    locked_d = InitLock[grant_q];
                    if (!InitLock[grant_q]) begin
                        last_grant_d = grant_q;
                    end
`else
                    last_grant_d = grant_q;
`endif
                    state_d = StAck;
                end
            end

            StAck: begin
                init_ack_d = '0;
                state_d    = StIdle;
            end

            default: begin
                init_ack_d = '0;
                tgt_req_d  = 1'b0;
                state_d    = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= GrantWidth'(NumInitiators - 1);
            init_ack_q   <= '0;
            init_data_q  <= '0;
            tgt_req_q    <= 1'b0;
            tgt_write_q  <= 1'b0;
            tgt_addr_q   <= '0;
            tgt_data_q   <= '0;
`ifdef RETRO_ARBITER_LOCK_EN
            locked_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            init_ack_q   <= init_ack_d;
            init_data_q  <= init_data_d;
            tgt_req_q    <= tgt_req_d;
            tgt_write_q  <= tgt_write_d;
            tgt_addr_q   <= tgt_addr_d;
            tgt_data_q   <= tgt_data_d;
`ifdef RETRO_ARBITER_LOCK_EN
            locked_q     <= locked_d;
`endif
        end
    end

    assign InitAck     = init_ack_q;
    assign InitDataOut = init_data_q;
    assign TgtRequest  = tgt_req_q;
    assign TgtWrite    = tgt_write_q;
    assign TgtAddress  = tgt_addr_q;
    assign TgtDataOut  = tgt_data_q;

endmodule

// File: tb/tb_retro_memory_arbiter.sv
// tb_retro_memory_arbiter
//   Directed bench for retro_memory_arbiter (2 initiators, 16-bit address,
//   8-bit data). Each scenario task drives its stimulus and checks the DUT
//   against hand-computed values. The lock scenario exists only when
//   RETRO_ARBITER_LOCK_EN is defined.
module tb_retro_memory_arbiter;

    logic        Clk;
    logic        nReset;
    logic [1:0]  InitRequest;
    logic [1:0]  InitWrite;
    logic [31:0] InitAddress;
    logic [15:0] InitDataIn;
`ifdef RETRO_ARBITER_LOCK_EN
    logic [1:0]  InitLock;
`endif
    logic [1:0]  InitAck;
    logic [7:0]  InitDataOut;
    logic        TgtRequest;
    logic        TgtWrite;
    logic [15:0] TgtAddress;
    logic [7:0]  TgtDataOut;
    logic        TgtAck;
    logic [7:0]  TgtDataIn;

    logic [15:0] addr0, addr1;
    logic [7:0]  data0, data1;

    int checks;
    int errors;

    assign InitAddress = {addr1, addr0};
    assign InitDataIn  = {data1, data0};

    retro_memory_arbiter #(
        .NumInitiators  (2),
        .AddressBusWidth(16),
        .DataBusWidth   (8)
    ) dut (
        .Clk        (Clk),
        .nReset     (nReset),
        .InitRequest(InitRequest),
        .InitWrite  (InitWrite),
        .InitAddress(InitAddress),
        .InitDataIn (InitDataIn),
`ifdef RETRO_ARBITER_LOCK_EN
        .InitLock   (InitLock),
`endif
        .InitAck    (InitAck),
        .InitDataOut(InitDataOut),
        .TgtRequest (TgtRequest),
        .TgtWrite   (TgtWrite),
        .TgtAddress (TgtAddress),
        .TgtDataOut (TgtDataOut),
        .TgtAck     (TgtAck),
        .TgtDataIn  (TgtDataIn)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        nReset      = 1'b0;
        InitRequest = 2'b11;
        InitWrite   = 2'b00;
        addr0 = 16'h0100; addr1 = 16'h0200;
        data0 = 8'h00;    data1 = 8'h00;
        TgtAck = 1'b0; TgtDataIn = 8'h00;
        tick(); tick();
        checks++;
        if ({InitAck, InitDataOut, TgtRequest, TgtWrite, TgtAddress, TgtDataOut} !== 36'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%b do=%h req=%b wr=%b addr=%h dout=%h, want all 0",
                     InitAck, InitDataOut, TgtRequest, TgtWrite, TgtAddress, TgtDataOut);
        end
        nReset = 1'b1;
        #1;
        checks++;
        if (TgtRequest !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_req: got %b want 0", TgtRequest);
        end
        tick();
        checks++;
        if (TgtRequest !== 1'b1 || TgtAddress !== 16'h0100) begin
            errors++;
            $display("FAIL first_grant: got req=%b addr=%h want req=1 addr=0100", TgtRequest, TgtAddress);
        end
        TgtAck = 1'b1; TgtDataIn = 8'h3C;
        tick();
        TgtAck = 1'b0; InitRequest = 2'b00;
        checks++;
        if (InitAck !== 2'b01 || InitDataOut !== 8'h3C) begin
            errors++;
            $display("FAIL first_ack: got ack=%b data=%h want ack=01 data=3c", InitAck, InitDataOut);
        end
        tick();
    endtask

    task automatic test_single_read();
        InitRequest = 2'b10; InitWrite = 2'b00; addr1 = 16'h1234;
        tick();
        checks++;
        if (TgtRequest !== 1'b1 || TgtAddress !== 16'h1234 || TgtWrite !== 1'b0) begin
            errors++;
            $display("FAIL read_fwd: got req=%b addr=%h wr=%b want 1 1234 0", TgtRequest, TgtAddress, TgtWrite);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (InitAck !== 2'b00 || TgtRequest !== 1'b1) begin
                errors++;
                $display("FAIL read_wait: got ack=%b req=%b want 00 1", InitAck, TgtRequest);
            end
        end
        TgtAck = 1'b1; TgtDataIn = 8'hA5;
        tick();
        TgtAck = 1'b0; TgtDataIn = 8'h00; InitRequest = 2'b00;
        checks++;
        if (InitAck !== 2'b10 || InitDataOut !== 8'hA5 || TgtRequest !== 1'b0) begin
            errors++;
            $display("FAIL read_ack: got ack=%b data=%h req=%b want 10 a5 0", InitAck, InitDataOut, TgtRequest);
        end
        tick();
        checks++;
        if (InitAck !== 2'b00) begin
            errors++;
            $display("FAIL read_ack_width: got %b want 00", InitAck);
        end
    endtask

    task automatic test_contention();
        logic [15:0] exp_addr;
        logic [7:0]  exp_data;
        logic [1:0]  exp_ack;
        InitWrite = 2'b11;
        addr0 = 16'h0100; addr1 = 16'h0200;
        data0 = 8'h11;    data1 = 8'h22;
        InitRequest = 2'b11;
        for (int t = 0; t < 8; t++) begin
            exp_addr = (t % 2 == 1) ? 16'h0200 : 16'h0100;
            exp_data = (t % 2 == 1) ? 8'h22 : 8'h11;
            exp_ack  = (t % 2 == 1) ? 2'b10 : 2'b01;
            tick();
            checks++;
            if (TgtRequest !== 1'b1 || TgtWrite !== 1'b1 || TgtAddress !== exp_addr || TgtDataOut !== exp_data) begin
                errors++;
                $display("FAIL contention_grant[%0d]: got req=%b wr=%b addr=%h d=%h want 1 1 %h %h",
                         t, TgtRequest, TgtWrite, TgtAddress, TgtDataOut, exp_addr, exp_data);
            end
            TgtAck = 1'b1;
            tick();
            TgtAck = 1'b0;
            checks++;
            if (InitAck !== exp_ack) begin
                errors++;
                $display("FAIL contention_ack[%0d]: got %b want %b", t, InitAck, exp_ack);
            end
            tick();
            checks++;
            if (InitAck !== 2'b00) begin
                errors++;
                $display("FAIL contention_ack_clear[%0d]: got %b want 00", t, InitAck);
            end
        end
        InitRequest = 2'b00;
        checks++;
        if (InitDataOut !== 8'hA5) begin
            errors++;
            $display("FAIL write_keeps_rdata: got %h want a5", InitDataOut);
        end
    endtask

    task automatic test_stability();
        InitRequest = 2'b01; InitWrite = 2'b01; addr0 = 16'h0AAA; data0 = 8'h5C;
        tick();
        checks++;
        if (TgtRequest !== 1'b1 || TgtAddress !== 16'h0AAA || TgtDataOut !== 8'h5C || TgtWrite !== 1'b1) begin
            errors++;
            $display("FAIL stable_grant: got req=%b addr=%h d=%h wr=%b want 1 0aaa 5c 1",
                     TgtRequest, TgtAddress, TgtDataOut, TgtWrite);
        end
        for (int i = 0; i < 20; i++) begin
            addr0 = 16'h1000 + 16'(i);
            data0 = 8'(i);
            InitWrite = {1'b0, i[0]};
            InitRequest = (i < 10) ? 2'b01 : 2'b00;
            tick();
            checks++;
            if (TgtRequest !== 1'b1 || TgtAddress !== 16'h0AAA || TgtDataOut !== 8'h5C ||
                TgtWrite !== 1'b1 || InitAck !== 2'b00) begin
                errors++;
                $display("FAIL stable_hold[%0d]: got req=%b addr=%h d=%h wr=%b ack=%b want 1 0aaa 5c 1 00",
                         i, TgtRequest, TgtAddress, TgtDataOut, TgtWrite, InitAck);
            end
        end
        TgtAck = 1'b1;
        tick();
        TgtAck = 1'b0;
        checks++;
        if (InitAck !== 2'b01 || InitDataOut !== 8'hA5) begin
            errors++;
            $display("FAIL stable_ack: got ack=%b data=%h want 01 a5", InitAck, InitDataOut);
        end
        tick();
        InitRequest = 2'b00;
        TgtAck = 1'b1; TgtDataIn = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (InitAck !== 2'b00 || TgtRequest !== 1'b0 || InitDataOut !== 8'hA5) begin
                errors++;
                $display("FAIL spurious_ack[%0d]: got ack=%b req=%b data=%h want 00 0 a5",
                         i, InitAck, TgtRequest, InitDataOut);
            end
        end
        TgtAck = 1'b0; TgtDataIn = 8'h00;
    endtask

    task automatic test_reset_mid_op();
        InitRequest = 2'b10; InitWrite = 2'b00; addr1 = 16'h2468;
        tick();
        checks++;
        if (TgtRequest !== 1'b1 || TgtAddress !== 16'h2468) begin
            errors++;
            $display("FAIL midop_busy: got req=%b addr=%h want 1 2468", TgtRequest, TgtAddress);
        end
        #2 nReset = 1'b0;
        #1;
        checks++;
        if (TgtRequest !== 1'b0 || TgtAddress !== 16'h0000 || InitAck !== 2'b00) begin
            errors++;
            $display("FAIL midop_busy_reset: got req=%b addr=%h ack=%b want 0 0000 00", TgtRequest, TgtAddress, InitAck);
        end
        InitRequest = 2'b11; addr0 = 16'h1357;
        #1 nReset = 1'b1;
        tick();
        checks++;
        if (TgtRequest !== 1'b1 || TgtAddress !== 16'h1357) begin
            errors++;
            $display("FAIL midop_regrant: got req=%b addr=%h want 1 1357", TgtRequest, TgtAddress);
        end
        TgtAck = 1'b1; TgtDataIn = 8'h77;
        tick();
        TgtAck = 1'b0;
        checks++;
        if (InitAck !== 2'b01) begin
            errors++;
            $display("FAIL midop_ack: got %b want 01", InitAck);
        end
        #2 nReset = 1'b0;
        #1;
        checks++;
        if (InitAck !== 2'b00 || InitDataOut !== 8'h00) begin
            errors++;
            $display("FAIL midop_ack_reset: got ack=%b data=%h want 00 00", InitAck, InitDataOut);
        end
        InitRequest = 2'b00;
        #1 nReset = 1'b1;
        tick();
    endtask

`ifdef RETRO_ARBITER_LOCK_EN
    task automatic test_lock();
        InitWrite = 2'b00; addr0 = 16'h0A00; addr1 = 16'h0B00;
        InitLock = 2'b10; InitRequest = 2'b10;
        for (int b = 0; b < 4; b++) begin
            tick();
            InitRequest = 2'b11;
            checks++;
            if (TgtRequest !== 1'b1 || TgtAddress !== 16'h0B00) begin
                errors++;
                $display("FAIL lock_beat[%0d]: got req=%b addr=%h want 1 0b00", b, TgtRequest, TgtAddress);
            end
            if (b == 3) InitLock = 2'b00;
            TgtAck = 1'b1;
            tick();
            TgtAck = 1'b0;
            if (b == 3) InitRequest = 2'b01;
            checks++;
            if (InitAck !== 2'b10) begin
                errors++;
                $display("FAIL lock_ack[%0d]: got %b want 10", b, InitAck);
            end
            tick();
        end
        tick();
        checks++;
        if (TgtRequest !== 1'b1 || TgtAddress !== 16'h0A00) begin
            errors++;
            $display("FAIL lock_release: got req=%b addr=%h want 1 0a00", TgtRequest, TgtAddress);
        end
        TgtAck = 1'b1;
        tick();
        TgtAck = 1'b0; InitRequest = 2'b00;
        tick();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
`ifdef RETRO_ARBITER_LOCK_EN
        InitLock = 2'b00;
`endif
        test_reset();
        test_single_read();
        test_contention();
        test_stability();
        test_reset_mid_op();
`ifdef RETRO_ARBITER_LOCK_EN
        test_lock();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
